// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU control codes and immediate formats.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_Z = 2'b11;

endpackage

// File: rtl/decode_cycle_regfile.sv
// 32x32 register file: two combinational read ports with writeback bypass, one posedge write port.
// x0 reads as zero and ignores writes; reset clears every register.
module register_file
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // A write landing this cycle is forwarded so the decoder never sees stale data.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 5'd0) rd1 = (wr_en && wa == ra1) ? wd : regs[ra1];
    if (ra2 != 5'd0) rd2 = (wr_en && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I ID stage: main/ALU decode, immediate extension, register read, and the ID/EX register.
// ID/EX loads on the falling edge; flush beats stall beats load.
module decode_cycle
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        StallE,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        ResultSrcE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] PCE,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RdE
);

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        reg_write, result_src, mem_write, branch, alu_src;
  logic [1:0]  imm_src, alu_op;
  logic [2:0]  alu_control;
  logic [31:0] imm_ext, rd1, rd2;

  assign op       = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7_5 = InstrD[30];

  register_file u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (InstrD[19:15]),
    .ra2 (InstrD[24:20]),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    unique case (op)
      OP_LOAD:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = 1'b1; end
      OP_STORE:  begin imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1; end
      OP_RTYPE:  begin reg_write = 1'b1; alu_op = 2'b10; end
      OP_ITYPE:  begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      OP_BRANCH: begin imm_src = IMM_B; branch = 1'b1; alu_op = 2'b01; end
      default:   ;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          // Only R-type with funct7[5] subtracts; addi reuses bit 30 as immediate.
          3'b000:  alu_control = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      ImmExtE     <= '0;
      PCPlus4E    <= '0;
      RdE         <= '0;
    end else if (!StallE) begin
      RegWriteE   <= reg_write;
      ResultSrcE  <= result_src;
      MemWriteE   <= mem_write;
      BranchE     <= branch;
      ALUSrcE     <= alu_src;
      ALUControlE <= alu_control;
      RD1E        <= rd1;
      RD2E        <= rd2;
      PCE         <= PCD;
      ImmExtE     <= imm_ext;
      PCPlus4E    <= PCPlus4D;
      RdE         <= InstrD[11:7];
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: inputs change 1ns after posedge, outputs sampled 1ns after negedge.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, StallE, FlushE;
  logic [4:0]  RdW;
  logic        RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  RdE;

  int errors = 0;
  int checks = 0;
  logic [31:0] pc = 32'h0000_1000;
  logic [31:0] held_pc;
  logic [31:0] rinstr;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .StallE(StallE), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
    .PCPlus4E(PCPlus4E), .RdE(RdE)
  );

  wire [7:0] ctrl = {RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] instr, input logic we, input logic [4:0] rd,
                      input logic [31:0] res, input logic st, input logic fl);
    @(posedge clk);
    #1;
    pc        = pc + 32'd4;
    InstrD    = instr;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
    RegWriteW = we;
    RdW       = rd;
    ResultW   = res;
    StallE    = st;
    FlushE    = fl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; InstrD = 32'h0020_81B3; PCD = 32'h40; PCPlus4D = 32'h44;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0; StallE = 1'b0; FlushE = 1'b0;
    #1;
    chk("reset_ctrl", {24'd0, ctrl}, 32'd0);
    chk("reset_pce", PCE, 32'd0);
    @(negedge clk); #1;
    chk("reset_held_rde", {27'd0, RdE}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // write x5 then read it back through add x7,x6,x5
    step(32'h0000_0013, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0);
    step(32'h0053_03B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("wr_rd2e", RD2E, 32'h0000_1234);
    chk("wr_rd1e", RD1E, 32'h0);
    chk("wr_rde", {27'd0, RdE}, 32'd7);
    chk("wr_ctrl", {24'd0, ctrl}, 32'h80);
    chk("wr_pce", PCE, pc);
    chk("wr_pcplus4e", PCPlus4E, pc + 32'd4);

    // same-cycle bypass
    step(32'h0053_03B3, 1'b1, 5'd5, 32'h0000_AAAA, 1'b0, 1'b0);
    chk("bypass_rd2e", RD2E, 32'h0000_AAAA);
    step(32'h0053_03B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("bypass_stored", RD2E, 32'h0000_AAAA);

    // x0 ignores writes and bypass
    step(32'h0000_03B3, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0);
    chk("x0_bypass", RD1E, 32'h0);
    step(32'h0000_03B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("x0_read", RD2E, 32'h0);

    // immediates
    step(32'hFFC1_2083, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("lw_imm", ImmExtE, 32'hFFFF_FFFC);
    chk("lw_ctrl", {24'd0, ctrl}, 32'hC8);
    step(32'h0051_2423, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("sw_imm", ImmExtE, 32'h8);
    chk("sw_ctrl", {24'd0, ctrl}, 32'h28);
    chk("sw_rd2e", RD2E, 32'h0000_AAAA);
    step(32'hFE20_8CE3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("beq_imm", ImmExtE, 32'hFFFF_FFF8);
    chk("beq_ctrl", {24'd0, ctrl}, 32'h11);

    // ALU decode
    step(32'h0020_A1B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("slt_ctrl", {24'd0, ctrl}, 32'h85);
    step(32'h0020_F1B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("and_ctrl", {24'd0, ctrl}, 32'h82);
    step(32'h0020_E1B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("or_ctrl", {24'd0, ctrl}, 32'h83);
    step(32'h4000_8193, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("addi_ctrl", {24'd0, ctrl}, 32'h88);
    chk("addi_imm", ImmExtE, 32'h0000_0400);
    step(32'h4020_81B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("sub_ctrl", {24'd0, ctrl}, 32'h81);
    held_pc = pc;

    // stall holds sub for two edges
    step(32'hFFC1_2083, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    step(32'h0051_2423, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("stall_ctrl", {24'd0, ctrl}, 32'h81);
    chk("stall_rde", {27'd0, RdE}, 32'd3);
    chk("stall_pce", PCE, held_pc);

    // flush, then flush+stall
    step(32'hFFC1_2083, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    chk("flush_ctrl", {24'd0, ctrl}, 32'h0);
    chk("flush_rde", {27'd0, RdE}, 32'd0);
    chk("flush_imm", ImmExtE, 32'h0);
    step(32'h0053_03B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("post_flush_ctrl", {24'd0, ctrl}, 32'h80);
    step(32'hFFC1_2083, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    chk("flush_stall_ctrl", {24'd0, ctrl}, 32'h0);
    chk("flush_stall_rde", {27'd0, RdE}, 32'd0);
    chk("flush_stall_pce", PCE, 32'h0);

    // undefined opcode acts as NOP
    step(32'h0000_0FFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("undef_ctrl", {24'd0, ctrl}, 32'h0);
    chk("undef_rde", {27'd0, RdE}, 32'd31);

    // mid-run reset clears pipeline and register file
    step(32'h0053_03B3, 1'b1, 5'd31, 32'h0000_DEAD, 1'b0, 1'b0);
    step(32'h01F0_03B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("x31_written", RD2E, 32'h0000_DEAD);
    rst = 1'b0;
    #1;
    chk("midreset_ctrl", {24'd0, ctrl}, 32'h0);
    chk("midreset_rd2e", RD2E, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rinstr = {7'd0, 5'(i), 5'(i), 3'b000, 5'd1, 7'b0110011};
      step(rinstr, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      chk($sformatf("clr_x%0d", i), RD1E | RD2E, 32'h0);
    end
    chk("post_reset_load", {24'd0, ctrl}, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
ID stage of the 5-stage RV32I pipeline, directly upstream of the execute stage. Decodes InstrD into control signals and sign-extends the immediate. Reads operands from an internal 32x32 register file, whose write port is driven by writeback. Captures everything into the ID/EX pipeline register that feeds the execute stage. Supports hold (stall) and bubble-insert (flush) controls for the future hazard unit.

Parameters:
XLEN, 32, datapath width
NREG, 32, register count (address width 5)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
InstrD  in  32  instruction from IF/ID
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  writeback write enable
RdW  in  5  writeback destination
ResultW  in  32  writeback data
StallE  in  1  hold ID/EX register
FlushE  in  1  load bubble into ID/EX
RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE  out  1 each  registered control
ALUControlE  out  3  registered ALU op
RD1E, RD2E  out  32  registered operands
PCE, ImmExtE, PCPlus4E  out  32  registered PC, immediate and PC+4
RdE  out  5  registered InstrD[11:7]

Behaviour:
- Reset (rst=0, async): all ID/EX outputs = 0; all 31 GPRs cleared.
- Register file:
  - Writes on posedge clk when RegWriteW=1 and RdW!=0.
  - x0 always reads 0; writes to x0 are ignored.
  - Reads are combinational on rs1=InstrD[19:15] and rs2=InstrD[24:20].
  - Same-cycle bypass: if RegWriteW=1, RdW!=0 and RdW equals a read address, that read returns ResultW.
- ID/EX register updates on negedge clk. Latency: decode-stage values appear on the E outputs at the first falling edge.
- Priority at each falling edge: rst > FlushE > StallE > load.
  - FlushE=1: all control outputs = 0 and RdE = 0; data outputs = 0.
  - StallE=1 (FlushE=0): all outputs hold.
  - Both FlushE and StallE = 1: flush wins.
- Main decoder (op = InstrD[6:0]), fields RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/Branch/ALUOp:
  - 0000011 lw: 1/00/1/0/1/0/00
  - 0100011 sw: 0/01/1/1/0/0/00
  - 0110011 R-type: 1/xx/0/0/0/0/10
  - 0010011 I-ALU: 1/00/1/0/0/0/10
  - 1100011 beq: 0/10/0/0/0/1/01
  - Any other opcode: all controls 0, ALUOp 00 (behaves as a NOP).
- ALU decoder (ALUControl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt):
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, by funct3:
    - 000: sub if {op[5], funct7[5]} = 11, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Other funct3: add.
- Immediate extension (sign-extended to 32 bits):
  - ImmSrc 00 (I): {20{I[31]}, I[31:20]}.
  - ImmSrc 01 (S): {20{I[31]}, I[31:25], I[11:7]}.
  - ImmSrc 10 (B): {19{I[31]}, I[31], I[7], I[30:25], I[11:8], 1'b0}.
  - ImmSrc 11: 0.
- Reset asserted mid-operation clears both the pipeline register and the register file immediately. The first post-reset falling edge loads normally.

Decomposition:
- Package rv_pkg holds:
  - Opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH.
  - ALUControl codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - ImmSrc codes.
- One sub-module: register_file (2 combinational read ports, 1 synchronous write port, x0 hardwired, bypass logic).
- Decoders, immediate extension and the ID/EX register stay inline.

Test Plan:
- Reset: rst=0 with any InstrD → all E outputs 0; after release, reading x1..x31 returns 0.
- Write then read: RegWriteW=1, RdW=5, ResultW=0x1234 at posedge. Then InstrD=0x005303B3 (add x7,x6,x5) → after negedge RD2E=0x1234, RdE=7, ALUControlE=000, RegWriteE=1, ALUSrcE=0.
- Bypass and x0:
  - Same-cycle write x5=0xAAAA while decoding a read of x5 → RD2E=0xAAAA.
  - Write x0=0xFFFF, then read x0 → 0.
- Immediates:
  - lw with imm=-4 (InstrD=0xFFC12083) → ImmExtE=0xFFFFFFFC, ResultSrcE=1.
  - sw with imm=8 → ImmExtE=8, MemWriteE=1, RegWriteE=0.
  - beq with offset -8 → ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001.
- ALU decode: sub (funct7[5]=1) → 001; slt → 101; and → 010; or → 011; addi with funct7-like bit [30]=1 → 000.
- Stall and flush:
  - StallE=1 for 2 edges → outputs frozen.
  - FlushE=1 → all controls and RdE = 0 next negedge.
  - FlushE=StallE=1 → flush result.
  - Undefined opcode 0x7F → all controls 0.
